// File: rtl/mseq_pkg.sv
// Shared types and helpers for the M-sequence seed dispatcher.
// Holds the FSM encoding, the seed-width calculation and the bit-slice helper.
package mseq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_WAIT    = 2'd2
  } state_e;

  // Widest chaotic value the slice helper accepts
  localparam int unsigned MAX_DATA_W = 128;

  function automatic int unsigned din_width(input int unsigned n_samp,
                                            input int unsigned slice_msb,
                                            input int unsigned slice_lsb);
    return 3 * n_samp * (slice_msb - slice_lsb + 1);
  endfunction

  // Raw bits v[msb:lsb], right-aligned; no sign handling
  function automatic logic [MAX_DATA_W-1:0] slice_bits(input logic [MAX_DATA_W-1:0] v,
                                                       input int unsigned msb,
                                                       input int unsigned lsb);
    logic [MAX_DATA_W-1:0] mask;
    mask = '1;
    mask = mask >> (MAX_DATA_W - (msb - lsb + 1));
    return (v >> lsb) & mask;
  endfunction

endpackage

// File: rtl/mseq_out_slot.sv
// One-entry valid/ready seed holding register with a one-hot channel tag.
// Pulses round_done when the seed for the last channel is handed over.
module mseq_out_slot #(
  parameter int unsigned N_CH  = 4,
  parameter int unsigned DIN_W = 294
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [DIN_W-1:0] i_din,
  input  logic [N_CH-1:0]  i_tag,
  input  logic [N_CH-1:0]  i_ready,
  output logic [DIN_W-1:0] o_din,
  output logic [N_CH-1:0]  o_valid,
  output logic             o_round_done,
  output logic             o_hold_c
);

  logic [DIN_W-1:0] r_din;
  logic [N_CH-1:0]  r_valid;
  logic             r_round_done;
  logic             w_drain;

  assign w_drain  = |(r_valid & i_ready);
  // Slot stays occupied through the next edge: a new seed here is an overrun
  assign o_hold_c = (|r_valid) & ~w_drain;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_din        <= '0;
      r_valid      <= '0;
      r_round_done <= 1'b0;
    end else begin
      r_round_done <= w_drain & r_valid[N_CH-1];
      if (i_load) begin
        r_valid <= i_tag;
        r_din   <= i_din;
      end else if (w_drain) begin
        r_valid <= '0;
      end
    end
  end

  assign o_din        = r_din;
  assign o_valid      = r_valid;
  assign o_round_done = r_round_done;

endmodule

// File: rtl/mseq_seed_dispatcher.sv
// Collects chaotic (x,y,z) samples, packs them into seeds and hands one seed
// to each M-sequence generator per chaotic iteration period.
module mseq_seed_dispatcher
  import mseq_pkg::*;
#(
  parameter int unsigned N_CH        = 4,
  parameter int unsigned N_SAMP      = 2,
  parameter int unsigned DATA_WIDTH  = 64,
  parameter int unsigned SLICE_MSB   = 51,
  parameter int unsigned SLICE_LSB   = 3,
  parameter int unsigned IDX_W       = 8,
  parameter int unsigned ITER_PERIOD = 242,
  localparam int unsigned DIN_W      = din_width(N_SAMP, SLICE_MSB, SLICE_LSB)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enable,
  input  logic                         n1_valid,
  input  logic signed [DATA_WIDTH-1:0] xn1,
  input  logic signed [DATA_WIDTH-1:0] yn1,
  input  logic signed [DATA_WIDTH-1:0] zn1,
  input  logic [IDX_W-1:0]             xyz_out_num,
  output logic [DIN_W-1:0]             mseq_din,
  output logic [N_CH-1:0]              mseq_din_valid,
  input  logic [N_CH-1:0]              mseq_din_ready,
  output logic                         round_done,
  output logic                         overrun,
  output logic                         sync_err,
  output logic                         busy
);

  localparam int unsigned SLICE_W = SLICE_MSB - SLICE_LSB + 1;
  localparam int unsigned TRIP_W  = 3 * SLICE_W;
  localparam int unsigned CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int unsigned SAMP_W  = (N_SAMP > 1) ? $clog2(N_SAMP) : 1;

  state_e            r_state, w_state_nxt;
  logic [CH_W-1:0]   r_ch_idx, w_ch_idx_nxt;
  logic [SAMP_W-1:0] r_samp_cnt, w_samp_cnt_nxt;
  logic [IDX_W-1:0]  r_exp_idx, w_exp_idx_nxt;
  logic [DIN_W-1:0]  r_shift, w_shift_nxt;
  logic              r_overrun, w_overrun_nxt;
  logic              r_sync_err, w_sync_err_nxt;
  logic              r_busy, w_busy_nxt;
  logic              w_accept, w_load, w_hold;
  logic [SLICE_W-1:0] w_slice_x, w_slice_y, w_slice_z;
  logic [TRIP_W-1:0] w_triple;
  logic [DIN_W-1:0]  w_packed;
  logic [N_CH-1:0]   w_tag;

  assign w_slice_x = SLICE_W'(slice_bits(MAX_DATA_W'(xn1), SLICE_MSB, SLICE_LSB));
  assign w_slice_y = SLICE_W'(slice_bits(MAX_DATA_W'(yn1), SLICE_MSB, SLICE_LSB));
  assign w_slice_z = SLICE_W'(slice_bits(MAX_DATA_W'(zn1), SLICE_MSB, SLICE_LSB));
  assign w_triple  = {w_slice_x, w_slice_y, w_slice_z};
  // Older triples move toward the MSBs; stale bits fall off the top
  assign w_packed  = (r_shift << TRIP_W) | DIN_W'(w_triple);
  assign w_tag     = N_CH'(1) << r_ch_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_ch_idx   <= '0;
      r_samp_cnt <= '0;
      r_exp_idx  <= '0;
      r_shift    <= '0;
      r_overrun  <= 1'b0;
      r_sync_err <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_ch_idx   <= w_ch_idx_nxt;
      r_samp_cnt <= w_samp_cnt_nxt;
      r_exp_idx  <= w_exp_idx_nxt;
      r_shift    <= w_shift_nxt;
      r_overrun  <= w_overrun_nxt;
      r_sync_err <= w_sync_err_nxt;
      r_busy     <= w_busy_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_ch_idx_nxt   = r_ch_idx;
    w_samp_cnt_nxt = r_samp_cnt;
    w_exp_idx_nxt  = r_exp_idx;
    w_shift_nxt    = r_shift;
    w_overrun_nxt  = 1'b0;
    w_sync_err_nxt = 1'b0;
    w_accept       = 1'b0;
    w_load         = 1'b0;

    if (!enable) begin
      w_state_nxt    = ST_IDLE;
      w_ch_idx_nxt   = '0;
      w_samp_cnt_nxt = '0;
      w_exp_idx_nxt  = '0;
      w_shift_nxt    = '0;
    end else if (n1_valid) begin
      unique case (r_state)
        ST_IDLE:    w_accept = (xyz_out_num == '0);
        ST_COLLECT: begin
          if (xyz_out_num == r_exp_idx) w_accept = 1'b1;
          else                          w_sync_err_nxt = 1'b1;
        end
        ST_WAIT: begin
          if (xyz_out_num == IDX_W'(ITER_PERIOD - 1)) begin
            w_state_nxt    = ST_COLLECT;
            w_exp_idx_nxt  = '0;
            w_samp_cnt_nxt = '0;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end

    if (w_accept) begin
      w_state_nxt   = ST_COLLECT;
      w_shift_nxt   = w_packed;
      w_exp_idx_nxt = r_exp_idx + IDX_W'(1);
      if (r_samp_cnt == SAMP_W'(N_SAMP - 1)) begin
        w_samp_cnt_nxt = '0;
        if (w_hold) begin
          w_overrun_nxt = 1'b1;
          w_ch_idx_nxt  = '0;
          w_state_nxt   = ST_WAIT;
        end else begin
          w_load = 1'b1;
          if (r_ch_idx == CH_W'(N_CH - 1)) begin
            w_ch_idx_nxt = '0;
            w_state_nxt  = ST_WAIT;
          end else begin
            w_ch_idx_nxt = r_ch_idx + CH_W'(1);
          end
        end
      end else begin
        w_samp_cnt_nxt = r_samp_cnt + SAMP_W'(1);
      end
    end

    w_busy_nxt = (w_state_nxt != ST_IDLE) | w_load | w_hold;
  end

  mseq_out_slot #(
    .N_CH  (N_CH),
    .DIN_W (DIN_W)
  ) u_out_slot (
    .clk          (clk),
    .rst          (rst),
    .i_load       (w_load),
    .i_din        (w_packed),
    .i_tag        (w_tag),
    .i_ready      (mseq_din_ready),
    .o_din        (mseq_din),
    .o_valid      (mseq_din_valid),
    .o_round_done (round_done),
    .o_hold_c     (w_hold)
  );

  assign overrun  = r_overrun;
  assign sync_err = r_sync_err;
  assign busy     = r_busy;

endmodule

// File: tb/tb_mseq_seed_dispatcher.sv
// Self-checking bench for mseq_seed_dispatcher: directed scenarios plus random
// traffic against a transaction-level reference model of the seed rounds.
module tb_mseq_seed_dispatcher;

  localparam int unsigned N_CH        = 4;
  localparam int unsigned N_SAMP      = 2;
  localparam int unsigned IDX_W       = 8;
  localparam int unsigned ITER_PERIOD = 242;
  localparam int unsigned SLICE_LSB   = 3;
  localparam int unsigned SLICE_W     = 49;
  localparam int unsigned TRIP_W      = 3 * SLICE_W;
  localparam int unsigned DIN_W       = N_SAMP * TRIP_W;
  localparam int MD_IDLE = 0, MD_COLLECT = 1, MD_WAIT = 2;

  logic clk = 1'b0;
  logic rst, enable, n1_valid;
  logic signed [63:0] xn1, yn1, zn1;
  logic [IDX_W-1:0] xyz_out_num;
  logic [DIN_W-1:0] mseq_din;
  logic [N_CH-1:0] mseq_din_valid, mseq_din_ready;
  logic round_done, overrun, sync_err, busy;

  always #5 clk = ~clk;

  mseq_seed_dispatcher dut (
    .clk(clk), .rst(rst), .enable(enable), .n1_valid(n1_valid),
    .xn1(xn1), .yn1(yn1), .zn1(zn1), .xyz_out_num(xyz_out_num),
    .mseq_din(mseq_din), .mseq_din_valid(mseq_din_valid),
    .mseq_din_ready(mseq_din_ready), .round_done(round_done),
    .overrun(overrun), .sync_err(sync_err), .busy(busy)
  );

  int n_vec = 0;
  int n_err = 0;
  bit fixed_data = 1'b0;

  // Reference model: round progress as plain counters and a sample queue
  int m_mode, m_exp, m_ch;
  logic [TRIP_W-1:0] m_samp[$];
  logic [N_CH-1:0]   m_valid;
  logic [DIN_W-1:0]  m_din;

  task automatic chk(input string tag, input logic [DIN_W-1:0] obs, input logic [DIN_W-1:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [TRIP_W-1:0] triple_of(input logic [63:0] x, input logic [63:0] y,
                                                  input logic [63:0] z);
    logic [SLICE_W-1:0] sx, sy, sz;
    sx = SLICE_W'(x >> SLICE_LSB);
    sy = SLICE_W'(y >> SLICE_LSB);
    sz = SLICE_W'(z >> SLICE_LSB);
    return {sx, sy, sz};
  endfunction

  function automatic logic [DIN_W-1:0] pack_seed();
    logic [DIN_W-1:0] r = '0;
    foreach (m_samp[i]) r = (r << TRIP_W) | DIN_W'(m_samp[i]);
    return r;
  endfunction

  task automatic model_reset();
    m_mode = MD_IDLE; m_exp = 0; m_ch = 0; m_samp.delete();
    m_valid = '0; m_din = '0;
  endtask

  // One clock: predict, advance, compare every output
  task automatic tick();
    logic [N_CH-1:0]  nv;
    logic [DIN_W-1:0] nd;
    logic [SLICE_W-1:0] all_ones;
    bit rd, ov, se, drained, acc;
    all_ones = '1;
    rd = 0; ov = 0; se = 0; acc = 0;
    drained = (m_valid & mseq_din_ready) != '0;
    rd = drained && m_valid[N_CH-1];
    nv = drained ? '0 : m_valid;
    nd = m_din;
    if (!enable) begin
      m_mode = MD_IDLE; m_exp = 0; m_ch = 0; m_samp.delete();
    end else if (n1_valid) begin
      case (m_mode)
        MD_IDLE:    acc = (xyz_out_num == 0);
        MD_COLLECT: if (int'(xyz_out_num) == m_exp) acc = 1; else se = 1;
        default:    if (int'(xyz_out_num) == ITER_PERIOD - 1) begin
                      m_mode = MD_COLLECT; m_exp = 0; m_samp.delete();
                    end
      endcase
    end
    if (acc) begin
      m_samp.push_back(triple_of(xn1, yn1, zn1));
      m_exp++;
      m_mode = MD_COLLECT;
      if (m_samp.size() == N_SAMP) begin
        if (nv != '0) begin
          ov = 1; m_mode = MD_WAIT; m_ch = 0;
        end else begin
          nv = N_CH'(1) << m_ch;
          nd = pack_seed();
          m_ch++;
          if (m_ch == N_CH) begin m_ch = 0; m_mode = MD_WAIT; end
        end
        m_samp.delete();
      end
    end
    @(posedge clk);
    #1;
    m_valid = nv;
    m_din   = nd;
    chk("valid", DIN_W'(mseq_din_valid), DIN_W'(nv));
    if (nv != '0) chk("din", mseq_din, nd);
    chk("round_done", DIN_W'(round_done), DIN_W'(rd));
    chk("overrun", DIN_W'(overrun), DIN_W'(ov));
    chk("sync_err", DIN_W'(sync_err), DIN_W'(se));
    chk("busy", DIN_W'(busy), DIN_W'((m_mode != MD_IDLE) || (nv != '0)));
    if (fixed_data && nv != '0) begin
      chk("x_slice0", DIN_W'(mseq_din[DIN_W-1 -: SLICE_W]), DIN_W'(all_ones));
      chk("x_slice1", DIN_W'(mseq_din[DIN_W-TRIP_W-1 -: SLICE_W]), DIN_W'(all_ones));
    end
    @(negedge clk);
  endtask

  task automatic send(input bit v, input int idx, input bit en, input logic [N_CH-1:0] rdy);
    n1_valid = v; xyz_out_num = IDX_W'(idx); enable = en; mseq_din_ready = rdy;
    if (fixed_data) begin
      xn1 = 64'sh000F_FFFF_FFFF_FFF8; yn1 = '0; zn1 = '0;
    end else begin
      xn1 = {$urandom, $urandom}; yn1 = {$urandom, $urandom}; zn1 = {$urandom, $urandom};
    end
    tick();
  endtask

  task automatic idle(input int n, input logic [N_CH-1:0] rdy);
    for (int k = 0; k < n; k++) send(1'b0, 0, 1'b1, rdy);
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; n1_valid = 1'b0; xn1 = '0; yn1 = '0; zn1 = '0;
    xyz_out_num = '0; mseq_din_ready = '0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_valid", DIN_W'(mseq_din_valid), '0);
    chk("rst_din", mseq_din, '0);
    chk("rst_flags", DIN_W'({round_done, overrun, sync_err, busy}), '0);
    rst = 1'b0;

    // Basic round, all generators ready
    for (int i = 0; i < 8; i++) send(1'b1, i, 1'b1, 4'b1111);
    idle(3, 4'b1111);

    // Fixed x pattern: x slices all ones, y/z zero
    fixed_data = 1'b1;
    send(1'b1, ITER_PERIOD - 1, 1'b1, 4'b1111);
    for (int i = 0; i < 8; i++) send(1'b1, i, 1'b1, 4'b1111);
    idle(2, 4'b1111);
    fixed_data = 1'b0;

    // Generator 1 stalls for 4 cycles after its seed arrives
    send(1'b1, ITER_PERIOD - 1, 1'b1, 4'b1111);
    for (int i = 0; i < 4; i++) send(1'b1, i, 1'b1, 4'b1111);
    idle(4, 4'b1101);
    for (int i = 4; i < 8; i++) begin
      send(1'b1, i, 1'b1, 4'b1111);
      idle(1, 4'b1111);
    end
    idle(2, 4'b1111);

    // Generator 0 never ready: second block overruns
    send(1'b1, ITER_PERIOD - 1, 1'b1, 4'b1111);
    for (int i = 0; i < 4; i++) send(1'b1, i, 1'b1, 4'b1110);
    idle(2, 4'b1110);
    idle(2, 4'b1111);

    // Out-of-order index is dropped
    send(1'b1, ITER_PERIOD - 1, 1'b1, 4'b1111);
    for (int i = 0; i < 4; i++) send(1'b1, i, 1'b1, 4'b1111);
    send(1'b1, 5, 1'b1, 4'b1111);
    for (int i = 4; i < 8; i++) send(1'b1, i, 1'b1, 4'b1111);
    idle(2, 4'b1111);

    // Enable drop mid-collect, then a fresh round from idle
    send(1'b1, ITER_PERIOD - 1, 1'b1, 4'b1111);
    for (int i = 0; i < 3; i++) send(1'b1, i, 1'b1, 4'b1111);
    send(1'b1, 3, 1'b0, 4'b1111);
    send(1'b1, 3, 1'b1, 4'b1111);
    for (int i = 0; i < 8; i++) send(1'b1, i, 1'b1, 4'b1111);
    idle(2, 4'b1111);

    // Random traffic
    for (int c = 0; c < 1500; c++) begin
      int r, idx;
      r = $urandom_range(0, 9);
      if (r < 7) idx = (m_mode == MD_COLLECT) ? m_exp : (m_mode == MD_WAIT) ? ITER_PERIOD - 1 : 0;
      else if (r == 7) idx = ITER_PERIOD - 1;
      else idx = $urandom_range(0, 255);
      send($urandom_range(0, 2) != 0, idx, $urandom_range(0, 99) != 0,
           N_CH'($urandom_range(0, 15)));
    end

    // Asynchronous reset with a seed pending
    send(1'b0, 0, 1'b0, 4'b0000);
    send(1'b1, 0, 1'b1, 4'b0000);
    send(1'b1, 1, 1'b1, 4'b0000);
    rst = 1'b1;
    #1;
    chk("arst_valid", DIN_W'(mseq_din_valid), '0);
    chk("arst_busy", DIN_W'(busy), '0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 2; i++) send(1'b1, i, 1'b1, 4'b1111);
    idle(2, 4'b1111);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
